// File: rtl/rfphoenix_ichit_plru.sv
// N-way I-cache tag compare with per-set tree pseudo-LRU and refill victim selection.
// Latency 2 clocks req->rvalid; stall_i freezes both stages and outputs (fills still touch PLRU).
module rfphoenix_ichit_plru #(
    parameter int LINES = 128,
    parameter int WAYS  = 4,
    parameter int AWID  = 32,
    parameter int LOBIT = 7,
    localparam int TAGW = AWID - LOBIT,
    localparam int NDXW = $clog2(LINES),
    localparam int WAYW = $clog2(WAYS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_i,
    input  logic                       stall_i,
    input  logic [AWID-1:0]            ip_i,
    input  logic [NDXW-1:0]            ndx_i,
    input  logic [WAYS-1:0][TAGW-1:0]  tag_i,
    input  logic [WAYS-1:0]            valid_i,
    input  logic                       upd_i,
    input  logic [NDXW-1:0]            upd_ndx_i,
    input  logic [WAYW-1:0]            upd_way_i,
    output logic                       rvalid_o,
    output logic                       hit_o,
    output logic [WAYW-1:0]            hit_way_o,
    output logic                       multihit_o,
    output logic [WAYW-1:0]            vway_o,
    output logic [TAGW-1:0]            vtag_o,
    output logic                       vvalid_o
);

    // Set every node on the path of 'way' to point away from it.
    function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] bits,
                                                   input logic [WAYW-1:0] way);
        logic [WAYS-2:0] r;
        int node;
        r    = bits;
        node = 0;
        for (int l = WAYW - 1; l >= 0; l--) begin
            r[node] = ~way[l];
            node    = 2 * node + 1 + int'(way[l]);
        end
        return r;
    endfunction

    function automatic logic [WAYW-1:0] plru_victim(input logic [WAYS-2:0] bits);
        logic [WAYW-1:0] w;
        int node;
        w    = '0;
        node = 0;
        for (int l = WAYW - 1; l >= 0; l--) begin
            w[l] = bits[node];
            node = 2 * node + 1 + int'(bits[node]);
        end
        return w;
    endfunction

    function automatic logic [WAYW-1:0] lowest_set(input logic [WAYS-1:0] v);
        logic [WAYW-1:0] r;
        r = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (v[w]) r = WAYW'(w);
        end
        return r;
    endfunction

    logic [WAYS-2:0]            plru [LINES];

    logic                       s1v;
    logic [WAYS-1:0]            s1_match;
    logic [NDXW-1:0]            s1_ndx;
    logic [WAYS-1:0][TAGW-1:0]  s1_tag;
    logic [WAYS-1:0]            s1_valid;
    logic [WAYW-1:0]            s1_vway;
    logic [NDXW-1:0]            s2_ndx;

    logic                       hit_touch;
    logic [WAYS-2:0]            hit_new;
    logic [WAYS-2:0]            fill_base;
    logic [WAYS-2:0]            fill_new;
    logic [WAYS-2:0]            lookup_bits;
    logic [WAYS-1:0]            match;
    logic [WAYW-1:0]            victim;
    logic                       unused_lo;

    assign unused_lo = ^ip_i[LOBIT-1:0];

    // Fill is chained after the hit so it wins on shared nodes of the same set.
    always_comb begin
        hit_touch = rvalid_o & hit_o & ~stall_i;
        hit_new   = plru_touch(plru[s2_ndx], hit_way_o);
        fill_base = (hit_touch && (upd_ndx_i == s2_ndx)) ? hit_new : plru[upd_ndx_i];
        fill_new  = plru_touch(fill_base, upd_way_i);
    end

    // Lookup sees this cycle's touches to its own set.
    always_comb begin
        lookup_bits = plru[ndx_i];
        if (upd_i && (upd_ndx_i == ndx_i))
            lookup_bits = fill_new;
        else if (hit_touch && (s2_ndx == ndx_i))
            lookup_bits = hit_new;
        for (int w = 0; w < WAYS; w++)
            match[w] = valid_i[w] && (tag_i[w] == ip_i[AWID-1:LOBIT]);
        if (&valid_i)
            victim = plru_victim(lookup_bits);
        else
            victim = lowest_set(~valid_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LINES; i++) plru[i] <= '0;
        end else begin
            if (hit_touch) plru[s2_ndx] <= hit_new;
            if (upd_i)     plru[upd_ndx_i] <= fill_new;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1v      <= 1'b0;
            s1_match <= '0;
            s1_ndx   <= '0;
            s1_tag   <= '0;
            s1_valid <= '0;
            s1_vway  <= '0;
        end else if (!stall_i) begin
            s1v      <= req_i;
            s1_match <= match;
            s1_ndx   <= ndx_i;
            s1_tag   <= tag_i;
            s1_valid <= valid_i;
            s1_vway  <= victim;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_o   <= 1'b0;
            hit_o      <= 1'b0;
            hit_way_o  <= '0;
            multihit_o <= 1'b0;
            vway_o     <= '0;
            vtag_o     <= '0;
            vvalid_o   <= 1'b0;
            s2_ndx     <= '0;
        end else if (!stall_i) begin
            rvalid_o <= s1v;
            if (s1v) begin
                hit_o      <= |s1_match;
                hit_way_o  <= lowest_set(s1_match);
                multihit_o <= |(s1_match & (s1_match - 1'b1));
                vway_o     <= s1_vway;
                vtag_o     <= s1_tag[s1_vway];
                vvalid_o   <= s1_valid[s1_vway];
                s2_ndx     <= s1_ndx;
            end else begin
                hit_o      <= 1'b0;
                multihit_o <= 1'b0;
                vvalid_o   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rfphoenix_ichit_plru.sv
// Directed bench for rfphoenix_ichit_plru with default parameters (4 ways, 128 sets, 25-bit tags).
module tb_rfphoenix_ichit_plru;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  req_i;
    logic                  stall_i;
    logic [31:0]           ip_i;
    logic [6:0]            ndx_i;
    logic [3:0][24:0]      tag_i;
    logic [3:0]            valid_i;
    logic                  upd_i;
    logic [6:0]            upd_ndx_i;
    logic [1:0]            upd_way_i;
    logic                  rvalid_o;
    logic                  hit_o;
    logic [1:0]            hit_way_o;
    logic                  multihit_o;
    logic [1:0]            vway_o;
    logic [24:0]           vtag_o;
    logic                  vvalid_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rfphoenix_ichit_plru dut (
        .clk(clk), .rst(rst), .req_i(req_i), .stall_i(stall_i), .ip_i(ip_i),
        .ndx_i(ndx_i), .tag_i(tag_i), .valid_i(valid_i), .upd_i(upd_i),
        .upd_ndx_i(upd_ndx_i), .upd_way_i(upd_way_i), .rvalid_o(rvalid_o),
        .hit_o(hit_o), .hit_way_o(hit_way_o), .multihit_o(multihit_o),
        .vway_o(vway_o), .vtag_o(vtag_o), .vvalid_o(vvalid_o)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [3:0][24:0] mk_tags(input logic [24:0] b);
        logic [3:0][24:0] t;
        for (int i = 0; i < 4; i++) t[i] = b + 25'(i);
        return t;
    endfunction

    // Called at a negedge; returns at the negedge where the result is visible.
    task automatic lookup(input logic [6:0] n, input logic [24:0] t,
                          input logic [3:0][24:0] tg, input logic [3:0] v);
        req_i   = 1'b1;
        ndx_i   = n;
        ip_i    = {t, 7'h15};
        tag_i   = tg;
        valid_i = v;
        @(negedge clk);
        req_i = 1'b0;
        upd_i = 1'b0;
        check("latency", {31'b0, rvalid_o}, 32'd0);
        @(negedge clk);
        check("rvalid", {31'b0, rvalid_o}, 32'd1);
    endtask

    logic [3:0][24:0] tg;

    initial begin
        rst = 1'b1; req_i = 1'b0; stall_i = 1'b0; ip_i = '0; ndx_i = '0;
        tag_i = '0; valid_i = '0; upd_i = 1'b0; upd_ndx_i = '0; upd_way_i = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_rvalid", {31'b0, rvalid_o}, 32'd0);
        check("rst_hit", {31'b0, hit_o}, 32'd0);
        check("rst_vtag", {7'b0, vtag_o}, 32'd0);
        check("rst_vway", {30'b0, vway_o}, 32'd0);

        // All-valid miss on a fresh set: PLRU all zero -> way 0.
        tg = mk_tags(25'h050);
        lookup(7'd5, 25'h1FFFF, tg, 4'hF);
        check("miss5_hit", {31'b0, hit_o}, 32'd0);
        check("miss5_vway", {30'b0, vway_o}, 32'd0);
        check("miss5_vvalid", {31'b0, vvalid_o}, 32'd1);
        check("miss5_vtag", {7'b0, vtag_o}, 32'h050);

        // Invalid ways win over PLRU.
        lookup(7'd5, 25'h1FFFF, tg, 4'b1011);
        check("inv_vway", {30'b0, vway_o}, 32'd2);
        check("inv_vvalid", {31'b0, vvalid_o}, 32'd0);
        check("inv_vtag", {7'b0, vtag_o}, 32'h052);
        lookup(7'd5, 25'h1FFFF, tg, 4'b1101);
        check("inv1_vway", {30'b0, vway_o}, 32'd1);

        // Hits to ways 0..3 on set 3 leave all nodes 0 -> victim way 0.
        tg = mk_tags(25'h100);
        for (int w = 0; w < 4; w++) begin
            lookup(7'd3, 25'h100 + 25'(w), tg, 4'hF);
            check("hit3_hit", {31'b0, hit_o}, 32'd1);
            check("hit3_way", {30'b0, hit_way_o}, 32'(w));
            check("hit3_multi", {31'b0, multihit_o}, 32'd0);
        end
        lookup(7'd3, 25'h1FFFF, tg, 4'hF);
        check("lru3_vway", {30'b0, vway_o}, 32'd0);
        check("lru3_vtag", {7'b0, vtag_o}, 32'h100);
        lookup(7'd3, 25'h100, tg, 4'hF);
        lookup(7'd3, 25'h1FFFF, tg, 4'hF);
        check("lru3b_vway", {30'b0, vway_o}, 32'd2);
        check("lru3b_vtag", {7'b0, vtag_o}, 32'h102);

        // Multi-hit: ways 1 and 3 both match.
        tg = mk_tags(25'h300);
        tg[1] = 25'h3AA;
        tg[3] = 25'h3AA;
        lookup(7'd11, 25'h3AA, tg, 4'hF);
        check("mh_hit", {31'b0, hit_o}, 32'd1);
        check("mh_way", {30'b0, hit_way_o}, 32'd1);
        check("mh_multi", {31'b0, multihit_o}, 32'd1);
        // Matching tag in an invalid way does not hit.
        lookup(7'd11, 25'h3AA, tg, 4'b0101);
        check("mh_inv_hit", {31'b0, hit_o}, 32'd0);

        // Stall with a hit on set 9 way 0 in S2; a fill of way 2 lands during the stall.
        tg = mk_tags(25'h900);
        lookup(7'd9, 25'h900, tg, 4'hF);
        stall_i = 1'b1;
        req_i   = 1'b1;
        ndx_i   = 7'd9;
        ip_i    = {25'h903, 7'h0};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            upd_i     = (i == 0);
            upd_ndx_i = 7'd9;
            upd_way_i = 2'd2;
            check("stall_rvalid", {31'b0, rvalid_o}, 32'd1);
            check("stall_hit", {31'b0, hit_o}, 32'd1);
            check("stall_way", {30'b0, hit_way_o}, 32'd0);
        end
        stall_i = 1'b0;
        req_i   = 1'b0;
        @(negedge clk);
        check("stall_once", {31'b0, rvalid_o}, 32'd0);
        // fill way2 then hit way0 -> root=1, node2=1 -> way 3
        lookup(7'd9, 25'h1FFFF, tg, 4'hF);
        check("stall_vway", {30'b0, vway_o}, 32'd3);

        // Same-cycle hit touch (way 0) and fill (way 1) on set 7, with a bypassed lookup.
        tg = mk_tags(25'h700);
        lookup(7'd7, 25'h700, tg, 4'hF);
        check("h7_hit", {31'b0, hit_o}, 32'd1);
        upd_i = 1'b1; upd_ndx_i = 7'd7; upd_way_i = 2'd1;
        lookup(7'd7, 25'h1FFFF, tg, 4'hF);
        check("byp7_vway", {30'b0, vway_o}, 32'd2);
        lookup(7'd7, 25'h1FFFF, tg, 4'hF);
        check("st7_vway", {30'b0, vway_o}, 32'd2);

        // Reset with a lookup in flight: no result, PLRU of set 3 cleared.
        tg = mk_tags(25'h100);
        req_i = 1'b1; ndx_i = 7'd3; ip_i = {25'h100, 7'h0}; tag_i = tg; valid_i = 4'hF;
        @(negedge clk);
        req_i = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_rvalid0", {31'b0, rvalid_o}, 32'd0);
        @(negedge clk);
        check("mrst_rvalid1", {31'b0, rvalid_o}, 32'd0);
        check("mrst_hit", {31'b0, hit_o}, 32'd0);
        lookup(7'd3, 25'h1FFFF, tg, 4'hF);
        check("mrst_vway", {30'b0, vway_o}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rfphoenix_ichit_plru.md
Name: rfphoenix_ichit_plru

Overview:
Parametrised successor to the I-cache hit detector. Performs an N-way set-associative tag compare in a 2-stage stallable pipeline and reports hit, hit way and multi-hit. Keeps per-set tree pseudo-LRU state and selects a refill victim way, preferring invalid ways. Sits between the I-cache tag/valid RAMs and the fetch/refill controller; the victim tag and valid outputs feed the victim cache.

Parameters:
LINES, 128, sets per way; power of 2, 2..1024.
WAYS, 4, associativity; power of 2, 2..8.
AWID, 32, code address width.
LOBIT, 7, tag LSB; tag = ip[AWID-1:LOBIT], TAGW = AWID-LOBIT.
NDXW = $clog2(LINES); WAYW = $clog2(WAYS) (derived, localparam).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_i  in  1  lookup request; accepted when !stall_i
stall_i  in  1  hold whole pipeline
ip_i  in  AWID  fetch address
ndx_i  in  NDXW  set index of lookup
tag_i  in  WAYS x TAGW  tags read for set ndx_i, one per way
valid_i  in  WAYS  valid bits for set ndx_i
upd_i  in  1  refill complete; touch PLRU
upd_ndx_i  in  NDXW  refilled set
upd_way_i  in  WAYW  refilled way
rvalid_o  out  1  result valid
hit_o  out  1  any way matched
hit_way_o  out  WAYW  matching way
multihit_o  out  1  more than one way matched (error)
vway_o  out  WAYW  victim way for set
vtag_o  out  TAGW  tag held in victim way
vvalid_o  out  1  victim way holds a valid line (victim-cache write needed)

Behaviour:
- Reset: all outputs 0; all PLRU bits 0; both pipeline valids 0.
- S1 (on clk, !stall_i): s1v<=req_i; register match[w] = tag_i[w]==ip_i[AWID-1:LOBIT] && valid_i[w]; register ndx, tag_i, valid_i, and victim computed from PLRU[ndx_i] plus valid_i.
- S2 (on clk, !stall_i): rvalid_o<=s1v; hit_o<=|match; hit_way_o = lowest-numbered matching way; multihit_o = popcount(match)>1; vway_o, vtag_o = tag of victim way, vvalid_o = valid of victim way.
- Latency: 2 clocks from accepted req_i to rvalid_o; one lookup per clock.
- When rvalid_o=0, hit_way_o, vway_o and vtag_o hold their last values; hit_o and multihit_o are 0.
- stall_i=1: all S1/S2 registers and outputs hold, req_i ignored, no PLRU update from hits.
- PLRU: WAYS-1 bits per set, heap-ordered tree, node 0 = root, children 2i+1 (lower ways) and 2i+2 (upper ways).
- PLRU victim walk: bit=0 go lower, bit=1 go upper.
- PLRU touch of way w: every node on w's path is set to point away from w (1 if w is in the lower subtree, else 0).
- Victim select: if any valid_i bit is 0, victim = lowest-numbered invalid way; else the PLRU walk result.
- PLRU hit touch: happens in the cycle where rvalid_o & hit_o & !stall_i, on the S2 set and hit_way_o.
- PLRU fill touch: upd_i touches upd_ndx_i/upd_way_i every cycle, regardless of stall_i.
- Simultaneous hit touch and fill touch to the same set: the fill is applied after the hit (fill wins on shared nodes). Different sets: both are applied.
- Bypass: S1 victim computation sees the PLRU state including any touch written in the same cycle to the same set. Back-to-back lookups therefore never use stale PLRU.
- Reset mid-operation: pipeline is flushed and PLRU cleared on the next clock; an in-flight lookup produces no rvalid_o.

Test Plan:
- Reset, then lookup set 5 with valid_i=4'hF and no tag match -> 2 clocks later rvalid_o=1, hit_o=0, vway_o=0, vvalid_o=1, vtag_o=tag_i[0].
- Hits on set 3 to ways 0,1,2,3 in order, then a miss lookup on set 3 -> vway_o=0. Then a hit on way 0 and a miss lookup -> vway_o=2.
- Miss with valid_i=4'b1011 -> vway_o=2, vvalid_o=0, regardless of PLRU state.
- tag_i[1] and tag_i[3] both equal the ip tag, with both ways valid -> hit_o=1, hit_way_o=1, multihit_o=1.
- Issue a lookup, assert stall_i for 3 clocks, then release -> rvalid_o stays high with outputs constant during the stall, no PLRU change, and the result appears exactly once after release.
- Same cycle: hit touch of set 7 way 0 and upd_i for set 7 way 1, then a miss lookup on set 7 -> root bit=1, node1=0 -> vway_o=2. A back-to-back lookup to the same set reflects the bypassed state.
